// File: rtl/keyboard_pkg.sv
// Shared scan-code set 2 constants, prefix-state encoding and digit lookup
// for the keyboard controller.
package keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } prefix_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_START = 8'h1B;
  localparam logic [7:0] CODE_PAUSE = 8'h4D;
  localparam logic [7:0] CODE_CLEAR = 8'h21;
  localparam logic [7:0] CODE_BKSP  = 8'h66;

  localparam logic [7:0] DIGIT_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  // Returns {hit, digit}; hit is 0 when the code is not a digit key.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 0; i < 10; i++) begin
      if (code == DIGIT_CODES[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/keyboard_controller_if.sv
// Received-byte stream from the PS/2 frame receiver to the scan-code decoder.
interface keyboard_controller_if;
  logic [7:0] rx_byte;
  logic       byte_valid;

  modport master (output rx_byte, output byte_valid);
  modport slave  (input  rx_byte, input  byte_valid);
endinterface

// File: rtl/keyboard_controller_ps2_rx.sv
// PS/2 receiver: synchronises the raw lines, assembles 11-bit frames, checks
// start/stop/parity and aborts frames stalled for TIMEOUT_CYCLES cycles.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  ps2_clock,
  input  logic                  ps2_data,
  keyboard_controller_if.master rx
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            ps2_clock_p0, ps2_clock_p1, ps2_clock_p2;
  logic            ps2_data_p0, ps2_data_p1;
  logic            fall;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic [9:0]      shift;
  logic [10:0]     frame;
  logic            frame_ok;

  assign fall     = ps2_clock_p2 & ~ps2_clock_p1;
  assign frame    = {ps2_data_p1, shift};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  // Data path: synchroniser and shift register carry no reset.
  always_ff @(posedge clk_in) begin
    ps2_data_p0 <= ps2_data;
    ps2_data_p1 <= ps2_data_p0;
    if (fall) shift <= {ps2_data_p1, shift[9:1]};
    if (fall && bit_cnt == 4'd10) rx.rx_byte <= frame[8:1];
  end

  // Clock synchroniser idles high so reset never manufactures a falling edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      ps2_clock_p0  <= 1'b1;
      ps2_clock_p1  <= 1'b1;
      ps2_clock_p2  <= 1'b1;
      bit_cnt       <= 4'd0;
      idle_cnt      <= '0;
      rx.byte_valid <= 1'b0;
    end else begin
      ps2_clock_p0  <= ps2_clock;
      ps2_clock_p1  <= ps2_clock_p0;
      ps2_clock_p2  <= ps2_clock_p1;
      rx.byte_valid <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt       <= 4'd0;
          rx.byte_valid <= frame_ok;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keyboard_controller.sv
// Keyboard controller: decodes scan-code set 2 bytes into held-key levels
// (start/pause/clear) and a four-digit BCD file_id entry register.
module keyboard_controller
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  output logic        pause,
  output logic        start,
  output logic        clear,
  output logic [15:0] file_id
);

  keyboard_controller_if rx_bus ();

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk_in    (clk_in),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .rx        (rx_bus.master)
  );

  prefix_t     state, state_nxt;
  logic        start_nxt, pause_nxt, clear_nxt;
  logic [15:0] file_id_nxt;
  logic [7:0]  last_make, last_make_nxt;
  logic [7:0]  code;
  logic [4:0]  digit;

  assign code  = rx_bus.rx_byte;
  assign digit = digit_lookup(code);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= ST_IDLE;
      start     <= 1'b0;
      pause     <= 1'b0;
      clear     <= 1'b0;
      file_id   <= 16'h0000;
      last_make <= 8'h00;
    end else begin
      state     <= state_nxt;
      start     <= start_nxt;
      pause     <= pause_nxt;
      clear     <= clear_nxt;
      file_id   <= file_id_nxt;
      last_make <= last_make_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    start_nxt     = start;
    pause_nxt     = pause;
    clear_nxt     = clear;
    file_id_nxt   = file_id;
    last_make_nxt = last_make;
    if (rx_bus.byte_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (code == CODE_BREAK) begin
            state_nxt = ST_BREAK;
          end else if (code == CODE_EXT) begin
            state_nxt = ST_EXT;
          end else begin
            if (code == CODE_START) start_nxt = 1'b1;
            if (code == CODE_PAUSE) pause_nxt = 1'b1;
            if (code == CODE_CLEAR) clear_nxt = 1'b1;
            // A repeated digit/backspace make is typematic repeat and ignored.
            if (digit[4] && code != last_make) begin
              file_id_nxt   = {file_id[11:0], digit[3:0]};
              last_make_nxt = code;
            end else if (code == CODE_BKSP && code != last_make) begin
              file_id_nxt   = {4'h0, file_id[15:4]};
              last_make_nxt = code;
            end
          end
        end
        ST_BREAK: begin
          if (code == CODE_START) start_nxt = 1'b0;
          if (code == CODE_PAUSE) pause_nxt = 1'b0;
          if (code == CODE_CLEAR) clear_nxt = 1'b0;
          last_make_nxt = 8'h00;
          state_nxt     = ST_IDLE;
        end
        ST_EXT: begin
          state_nxt = (code == CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        end
        ST_EXT_BREAK: begin
          last_make_nxt = 8'h00;
          state_nxt     = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_controller.sv
// Directed bench for keyboard_controller: drives PS/2 frames bit by bit and
// checks the decoded key levels and file_id register.
module tb_keyboard_controller;

  logic        clk_in    = 1'b0;
  logic        reset     = 1'b1;
  logic        ps2_clock = 1'b1;
  logic        ps2_data  = 1'b1;
  logic        pause, start, clear;
  logic [15:0] file_id;
  int          errors = 0;
  int          checks = 0;

  keyboard_controller dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .pause     (pause),
    .start     (start),
    .clear     (clear),
    .file_id   (file_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Sends the low nbits of a frame; returns 4 cycles after the last falling edge.
  task automatic send_bits(input logic [10:0] frame, input int nbits);
    ps2_clock = 1'b1;
    wait_cycles(8);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_cycles(4);
      ps2_clock = 1'b0;
      wait_cycles(4);
      if (i != nbits - 1) ps2_clock = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    logic p;
    p = (~^b) ^ bad_parity;
    send_bits({1'b1, p, b, 1'b0}, 11);
  endtask

  task automatic make(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  task automatic brk(input logic [7:0] b);
    send_frame(8'hF0, 1'b0);
    send_frame(b, 1'b0);
  endtask

  task automatic do_reset();
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    wait_cycles(8);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pause); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", clear); end
    checks++; if (file_id !== 16'h0000) begin errors++; $display("FAIL reset_file_id: got %h expected 0000", file_id); end
  endtask

  task automatic test_start_key();
    do_reset();
    make(8'h1B);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_make_latency: got %b expected 1", start); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL start_make_pause: got %b expected 0", pause); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL start_make_clear: got %b expected 0", clear); end
    brk(8'h1B);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_break: got %b expected 0", start); end
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL start_break_pause: got %b expected 0", pause); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL start_break_clear: got %b expected 0", clear); end
  endtask

  task automatic test_digits();
    logic [7:0] codes [5];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      make(codes[i]);
      brk(codes[i]);
    end
    checks++; if (file_id !== 16'h2345) begin errors++; $display("FAIL digits_12345: got %h expected 2345", file_id); end
    make(8'h66);
    checks++; if (file_id !== 16'h0234) begin errors++; $display("FAIL backspace: got %h expected 0234", file_id); end
    make(8'h66);
    checks++; if (file_id !== 16'h0234) begin errors++; $display("FAIL backspace_repeat: got %h expected 0234", file_id); end
    brk(8'h66);
    make(8'h45);
    checks++; if (file_id !== 16'h2340) begin errors++; $display("FAIL digit_0: got %h expected 2340", file_id); end
    brk(8'h45);
    make(8'h46);
    checks++; if (file_id !== 16'h3409) begin errors++; $display("FAIL digit_9: got %h expected 3409", file_id); end
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 3; i++) make(8'h3D);
    checks++; if (file_id !== 16'h0007) begin errors++; $display("FAIL typematic_7: got %h expected 0007", file_id); end
  endtask

  task automatic test_bad_frames();
    do_reset();
    send_frame(8'h4D, 1'b1);
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL bad_parity: got pause=%b expected 0", pause); end
    send_frame(8'h4D, 1'b0);
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL good_after_bad: got pause=%b expected 1", pause); end
    send_bits({1'b0, ~^8'h21, 8'h21, 1'b0}, 11);
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL bad_stop: got clear=%b expected 0", clear); end
    make(8'h21);
    checks++; if (clear !== 1'b1) begin errors++; $display("FAIL good_after_stop: got clear=%b expected 1", clear); end
  endtask

  task automatic test_extended();
    do_reset();
    make(8'hE0); make(8'h4D);
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL ext_make: got pause=%b expected 0", pause); end
    make(8'h4D);
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL plain_after_ext: got pause=%b expected 1", pause); end
    make(8'hE0); make(8'hF0); make(8'h4D);
    checks++; if (pause !== 1'b1) begin errors++; $display("FAIL ext_break: got pause=%b expected 1", pause); end
    brk(8'h4D);
    checks++; if (pause !== 1'b0) begin errors++; $display("FAIL break_after_ext: got pause=%b expected 0", pause); end
    checks++; if (file_id !== 16'h0000) begin errors++; $display("FAIL ext_file_id: got %h expected 0000", file_id); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_bits({1'b1, ~^8'h21, 8'h21, 1'b0}, 6);
    wait_cycles(60000);
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL partial_frame: got clear=%b expected 0", clear); end
    make(8'h21);
    checks++; if (clear !== 1'b1) begin errors++; $display("FAIL after_timeout: got clear=%b expected 1", clear); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    make(8'h1B); make(8'h4D); make(8'h21);
    checks++; if ({start, pause, clear} !== 3'b111) begin errors++; $display("FAIL all_held: got spc=%b expected 111", {start, pause, clear}); end
    brk(8'h4D);
    checks++; if ({start, pause, clear} !== 3'b101) begin errors++; $display("FAIL pause_released: got spc=%b expected 101", {start, pause, clear}); end
    brk(8'h1B);
    checks++; if ({start, pause, clear} !== 3'b001) begin errors++; $display("FAIL start_released: got spc=%b expected 001", {start, pause, clear}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    make(8'h1B);
    make(8'h16); brk(8'h16); make(8'h1E);
    checks++; if ({start, file_id} !== {1'b1, 16'h0012}) begin errors++; $display("FAIL pre_reset: got start=%b file_id=%h expected 1 0012", start, file_id); end
    ps2_clock = 1'b1;
    wait_cycles(8);
    reset = 1'b1;
    wait_cycles(1);
    checks++; if ({start, pause, clear, file_id} !== 19'h0) begin errors++; $display("FAIL reset_pulse: got spc=%b file_id=%h expected 000 0000", {start, pause, clear}, file_id); end
    reset = 1'b0;
    wait_cycles(2);
    send_bits({1'b1, ~^8'h21, 8'h21, 1'b0}, 5);
    ps2_clock = 1'b1;
    wait_cycles(8);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);
    make(8'h4D);
    checks++; if ({pause, clear} !== 2'b10) begin errors++; $display("FAIL after_mid_reset: got pause,clear=%b expected 10", {pause, clear}); end
  endtask

  initial begin
    test_reset();
    test_start_key();
    test_digits();
    test_typematic();
    test_bad_frames();
    test_extended();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keyboard_controller.md
KEYBOARD_CONTROLLER -- requirements
Module: keyboard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: number of clk_in cycles of ps2_clock inactivity after which a partial frame is aborted (1 ms at 50 MHz).
REQ-002 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port ps2_clock  input  1  raw PS/2 clock from the keyboard; asynchronous to clk_in.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data; asynchronous to clk_in.
REQ-006 SHALL have port pause  output  1  level; high while the P key is held.
REQ-007 SHALL have port start  output  1  level; high while the S key is held.
REQ-008 SHALL have port clear  output  1  level; high while the C key is held.
REQ-009 SHALL have port file_id  output  16  four packed BCD digits entered from the keyboard; the newest digit is in [3:0].

Function
REQ-010 SHALL pass ps2_clock and ps2_data through two-flop synchronisers before any use.
REQ-011 SHALL sample ps2_data on each synchronised falling edge of ps2_clock.
REQ-012 SHALL assemble 11-bit frames: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
REQ-013 SHALL accept a byte only if start=0, stop=1 and the nine data+parity bits have odd parity; otherwise it SHALL discard the byte silently, leaving prefix flags unchanged.
REQ-014 SHALL abort a partial frame (bit counter to 0) when no falling edge arrives for TIMEOUT_CYCLES cycles mid-frame.
REQ-015 SHALL apply the effect of an accepted byte on outputs no later than 4 clk_in cycles after the 11th ps2_clock falling edge at the pin.
REQ-016 SHALL decode scan code set 2 with a prefix state machine: IDLE, BREAK (after 0xF0), EXT (after 0xE0), EXT_BREAK (0xE0 then 0xF0).
REQ-017 On 0xF0 in IDLE, SHALL go to BREAK; on 0xE0 in IDLE, SHALL go to EXT; on 0xF0 in EXT, SHALL go to EXT_BREAK.
REQ-018 SHALL ignore any code completing EXT or EXT_BREAK (extended keys) and return to IDLE.
REQ-019 SHALL treat a make code in IDLE as follows: 0x1B sets start, 0x4D sets pause, 0x21 sets clear.
REQ-020 SHALL treat a break code in BREAK as follows: 0x1B clears start, 0x4D clears pause, 0x21 clears clear; it then returns to IDLE.
REQ-021 SHALL map digit make codes 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 to digits 0..9.
REQ-022 On a digit make, SHALL set file_id <= {file_id[11:0], digit}, with the oldest digit dropped.
REQ-023 On backspace make (0x66), SHALL set file_id <= {4'h0, file_id[15:4]}.
REQ-024 SHALL keep a last_make register: a digit or backspace make equal to last_make (typematic repeat) SHALL be ignored; any break SHALL clear last_make to 0x00.
REQ-025 SHALL ignore all other codes, with no output change.
REQ-026 SHALL handle start, pause and clear independently; simultaneous holds are legal and each output follows its own key.

Reset
REQ-027 While reset=1 at a clk_in edge, SHALL drive start=pause=clear=0, file_id=16'h0000, prefix state IDLE, last_make=0x00, bit counter 0 and timeout counter 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the next frame SHALL be decoded normally.

Structure
REQ-029 SHALL put scan-code constants (0xF0, 0xE0, 0x1B, 0x4D, 0x21, 0x66, digit codes) and the prefix-state enum in a shared package keyboard_pkg.
REQ-030 SHALL implement the synchroniser, frame receiver and timeout in one sub-module ps2_rx, outputting an 8-bit byte and a 1-cycle byte_valid strobe; decode SHALL live in keyboard_controller.

Verification
REQ-031 Frame 0x1B: start=1 within 4 cycles of the last falling edge; then frames F0,1B: start=0; pause and clear stay 0 throughout.
REQ-032 Digits 1,2,3,4,5 (make+break each): file_id=16'h2345; then 0x66 make: file_id=16'h0234.
REQ-033 Digit 7 make sent three times without a break: file_id=16'h0007, not 16'h0777.
REQ-034 Frame 0x4D with bad parity: pause stays 0; a following correct 0x4D: pause=1.
REQ-035 Frames E0,4D then E0,F0,4D: no output change; 6 data bits then 60000 idle cycles then full 0x21 frame: clear=1.
REQ-036 Reset pulse while start=1 and file_id=16'h0012: all outputs 0 on the next cycle.
